// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: data width, MUL iteration count,
// external ALU operation encodings, command opcodes, sequencer states and the
// opcode -> ALU control mapping.
package alu_pkg;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned MUL_ITERS = 24;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS + 1);
  localparam logic [CNT_W-1:0] MUL_CNT_END = CNT_W'(MUL_ITERS);

  // Operation select of the external ALU
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLT = 3'b011
  } alu_op_e;

  // Command opcodes; 7..15 are illegal
  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_SLT = 4'd4,
    OP_NOR = 4'd5,
    OP_MUL = 4'd6
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL_LOOP,
    RESP
  } state_e;

  typedef struct packed {
    logic    a_invert;
    logic    b_negate;
    alu_op_e op;
  } alu_ctrl_t;

  // ALU control word for a legal opcode; MUL reuses the ADD controls.
  function automatic alu_ctrl_t alu_ctrl(input logic [3:0] op);
    alu_ctrl_t c;
    c = '0;
    case (op)
      OP_AND: c.op = ALU_AND;
      OP_OR:  c.op = ALU_OR;
      OP_ADD,
      OP_MUL: c.op = ALU_ADD;
      OP_SUB: begin
        c.b_negate = 1'b1;
        c.op       = ALU_ADD;
      end
      OP_SLT: begin
        c.b_negate = 1'b1;
        c.op       = ALU_SLT;
      end
      OP_NOR: begin
        c.a_invert = 1'b1;
        c.b_negate = 1'b1;
        c.op       = ALU_AND;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one command at a time, drives an external 24-bit ALU
// (single-cycle ops in EXEC, shift-and-add multiply in MUL_LOOP) and holds the
// response until it is taken.
//   Clock, Reset (sync, active low)
//   CmdValid/CmdReady, CmdOp, CmdA, CmdB       : command handshake
//   AluA, AluB, AluAInvert, AluBNegate, AluOp  : drive to external ALU
//   AluResult, AluZero, AluOverflow, AluCarryOut : combinational ALU return
//   RspValid/RspReady, RspResult, RspFlags {N,Z,V,C}, RspErr : response
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [3:0]        CmdOp,
  input  logic [DATA_W-1:0] CmdA,
  input  logic [DATA_W-1:0] CmdB,
  output logic [DATA_W-1:0] AluA,
  output logic [DATA_W-1:0] AluB,
  output logic              AluAInvert,
  output logic              AluBNegate,
  output logic [2:0]        AluOp,
  input  logic [DATA_W-1:0] AluResult,
  input  logic              AluZero,
  input  logic              AluOverflow,
  input  logic              AluCarryOut,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspResult,
  output logic [3:0]        RspFlags,
  output logic              RspErr
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] opa_q, opa_d;   // operand A / multiplicand
  logic [DATA_W-1:0] opb_q, opb_d;   // operand B / multiplier
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_err_q, rsp_err_d;
  alu_ctrl_t         ctrl;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    ctrl         = '0;
    AluA         = '0;
    AluB         = '0;

    unique case (state_q)
      IDLE: begin
        if (CmdValid && cmd_ready_q) begin
          op_d  = CmdOp;
          opa_d = CmdA;
          opb_d = CmdB;
          acc_d = '0;
          cnt_d = '0;
          case (CmdOp)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: state_d = EXEC;
            OP_MUL: state_d = MUL_LOOP;
            default: begin
              state_d      = RESP;
              rsp_result_d = '0;
              rsp_flags_d  = '0;
              rsp_err_d    = 1'b1;
            end
          endcase
        end
      end

      EXEC: begin
        ctrl         = alu_ctrl(op_q);
        AluA         = opa_q;
        AluB         = opb_q;
        rsp_result_d = AluResult;
        rsp_flags_d  = {AluResult[DATA_W-1], AluZero, AluOverflow, AluCarryOut};
        rsp_err_d    = 1'b0;
        state_d      = RESP;
      end

      MUL_LOOP: begin
        // Counts 0..MUL_ITERS-1 are the iterations; the extra cycle at
        // MUL_CNT_END latches the finished accumulator into the response.
        if (cnt_q != MUL_CNT_END) begin
          ctrl = alu_ctrl(OP_MUL);
          AluA = acc_q;
          AluB = opa_q;
          if (opb_q[0]) acc_d = AluResult;
          opa_d = {opa_q[DATA_W-2:0], 1'b0};
          opb_d = {1'b0, opb_q[DATA_W-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          rsp_result_d = acc_q;
          rsp_flags_d  = {acc_q[DATA_W-1], (acc_q == '0), 1'b0, 1'b0};
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (RspReady) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    AluAInvert  = ctrl.a_invert;
    AluBNegate  = ctrl.b_negate;
    AluOp       = ctrl.op;
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign CmdReady  = cmd_ready_q;
  assign RspValid  = rsp_valid_q;
  assign RspResult = rsp_result_q;
  assign RspFlags  = rsp_flags_q;
  assign RspErr    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: an external ALU model, a cycle-level
// reference model of the command/response behaviour, directed literal cases
// and a randomized phase.
module tb_alu_sequencer;

  logic        Clock;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [3:0]  CmdOp;
  logic [23:0] CmdA, CmdB;
  logic [23:0] AluA, AluB;
  logic        AluAInvert, AluBNegate;
  logic [2:0]  AluOp;
  logic [23:0] AluResult;
  logic        AluZero, AluOverflow, AluCarryOut;
  logic        RspValid, RspReady;
  logic [23:0] RspResult;
  logic [3:0]  RspFlags;
  logic        RspErr;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp), .CmdA(CmdA), .CmdB(CmdB),
    .AluA(AluA), .AluB(AluB), .AluAInvert(AluAInvert), .AluBNegate(AluBNegate), .AluOp(AluOp),
    .AluResult(AluResult), .AluZero(AluZero), .AluOverflow(AluOverflow), .AluCarryOut(AluCarryOut),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult), .RspFlags(RspFlags),
    .RspErr(RspErr)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // External ALU: optional invert of A, optional negate of B (invert + carry-in).
  // Logic operations report no overflow or carry.
  logic [23:0] ea, eb;
  logic [24:0] esum;
  logic        eovf;
  always_comb begin
    ea   = AluAInvert ? ~AluA : AluA;
    eb   = AluBNegate ? ~AluB : AluB;
    esum = {1'b0, ea} + {1'b0, eb} + {24'b0, AluBNegate};
    eovf = (ea[23] == eb[23]) && (esum[23] != ea[23]);
    AluResult   = '0;
    AluOverflow = 1'b0;
    AluCarryOut = 1'b0;
    case (AluOp)
      3'b000: AluResult = ea & eb;
      3'b001: AluResult = ea | eb;
      3'b010: begin
        AluResult   = esum[23:0];
        AluOverflow = eovf;
        AluCarryOut = esum[24];
      end
      3'b011: begin
        AluResult   = {23'b0, esum[23] ^ eovf};
        AluOverflow = eovf;
        AluCarryOut = esum[24];
      end
      default: AluResult = '0;
    endcase
    AluZero = (AluResult == '0);
  end

  // ---------------- reference model (arithmetic level) ----------------
  function automatic logic [23:0] ref_result(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
    logic [47:0] p;
    p = {24'b0, a} * {24'b0, b};
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return ($signed(a) < $signed(b)) ? 24'd1 : 24'd0;
      4'd5: return ~(a | b);
      4'd6: return p[23:0];
      default: return 24'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
    logic [23:0] r, d;
    logic [24:0] s;
    logic v, c;
    r = ref_result(op, a, b);
    s = {1'b0, a} + {1'b0, b};
    d = a - b;
    v = 1'b0;
    c = 1'b0;
    case (op)
      4'd2: begin
        c = s[24];
        v = (a[23] == b[23]) && (s[23] != a[23]);
      end
      4'd3, 4'd4: begin
        c = (a >= b);
        v = (a[23] != b[23]) && (d[23] != a[23]);
      end
      default: ;
    endcase
    if (op > 4'd6) return 4'b0000;
    return {r[23], (r == 24'd0), v, c};
  endfunction

  // {AluAInvert, AluBNegate, AluOp} table
  function automatic logic [4:0] spec_ctrl(input logic [3:0] op);
    case (op)
      4'd0: return 5'b00_000;
      4'd1: return 5'b00_001;
      4'd2: return 5'b00_010;
      4'd3: return 5'b01_010;
      4'd4: return 5'b01_011;
      4'd5: return 5'b11_000;
      4'd6: return 5'b00_010;
      default: return 5'b00_000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state: a command accepted at edge m_t shows its response from
  // cycle m_t + m_lat until an edge with RspReady.
  int          edge_n  = 0;
  bit          started = 0;
  bit          m_active = 0;
  int          m_t, m_lat;
  logic [3:0]  m_op;
  logic [23:0] m_a, m_b, m_er;
  logic [3:0]  m_ef;
  logic        m_ee;

  initial begin
    forever begin
      @(posedge Clock);
      edge_n++;
      if (!Reset) begin
        m_active = 0;
        started  = 1;
      end else if (started && !m_active) begin
        if (CmdValid) begin
          m_active = 1;
          m_t  = edge_n;
          m_op = CmdOp;
          m_a  = CmdA;
          m_b  = CmdB;
          m_lat = (CmdOp <= 4'd5) ? 2 : (CmdOp == 4'd6) ? 26 : 1;
          m_er = ref_result(CmdOp, CmdA, CmdB);
          m_ef = ref_flags(CmdOp, CmdA, CmdB);
          m_ee = (CmdOp > 4'd6);
        end
      end else if (m_active && (edge_n - m_t) >= m_lat && RspReady) begin
        m_active = 0;
      end
    end
  end

  // Compare process: every cycle once reset has been applied
  initial begin
    int cur, rel, i;
    logic [23:0] bm, sh;
    logic [47:0] prod;
    forever begin
      @(negedge Clock);
      if (started) begin
        cur = edge_n + 1;
        if (!m_active) begin
          chk("idle CmdReady", CmdReady, 1);
          chk("idle RspValid", RspValid, 0);
          chk("idle AluA", AluA, 0);
          chk("idle AluB", AluB, 0);
          chk("idle AluCtrl", {AluAInvert, AluBNegate, AluOp}, 0);
        end else begin
          rel = cur - m_t;
          if (rel >= m_lat) begin
            chk("resp RspValid", RspValid, 1);
            chk("resp CmdReady", CmdReady, 0);
            chk("resp RspResult", RspResult, m_er);
            chk("resp RspFlags", RspFlags, m_ef);
            chk("resp RspErr", RspErr, m_ee);
            chk("resp AluA", AluA, 0);
            chk("resp AluB", AluB, 0);
            chk("resp AluCtrl", {AluAInvert, AluBNegate, AluOp}, 0);
          end else begin
            chk("busy CmdReady", CmdReady, 0);
            chk("busy RspValid", RspValid, 0);
            if (m_op <= 4'd5 && rel == 1) begin
              chk("exec AluA", AluA, m_a);
              chk("exec AluB", AluB, m_b);
              chk("exec AluCtrl", {AluAInvert, AluBNegate, AluOp}, spec_ctrl(m_op));
            end else if (m_op == 4'd6 && rel <= 24) begin
              i    = rel - 1;
              bm   = m_b & ((24'h1 << i) - 24'h1);
              prod = {24'b0, m_a} * {24'b0, bm};
              sh   = m_a << i;
              chk("mul AluA", AluA, prod[23:0]);
              chk("mul AluB", AluB, sh);
              chk("mul AluCtrl", {AluAInvert, AluBNegate, AluOp}, 5'b00_010);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic run_cmd(input string nm, input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] er, input logic [3:0] ef, input logic ee, input int elat);
    int t;
    bit seen;
    step();
    chk({nm, " ready"}, CmdReady, 1);
    CmdValid = 1; CmdOp = op; CmdA = a; CmdB = b; RspReady = 1;
    @(negedge Clock);
    t = edge_n;
    #1;
    CmdValid = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (RspValid) begin
        seen = 1;
        chk({nm, " latency"}, edge_n + 1 - t, elat);
        chk({nm, " result"}, RspResult, er);
        chk({nm, " flags"}, RspFlags, ef);
        chk({nm, " err"}, RspErr, ee);
        if (op > 4'd6) begin
          chk({nm, " alu idle a"}, AluA, 0);
          chk({nm, " alu idle op"}, {AluAInvert, AluBNegate, AluOp}, 0);
        end
      end else begin
        step();
      end
    end
    if (!seen) chk({nm, " timeout"}, 0, 1);
    step();
  endtask

  function automatic logic [23:0] pick();
    case ($urandom % 6)
      0: return 24'h000000;
      1: return 24'h7FFFFF;
      2: return 24'h800000;
      3: return 24'hFFFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    int t;
    Reset = 0; CmdValid = 0; CmdOp = 0; CmdA = 0; CmdB = 0; RspReady = 1;
    repeat (3) step();
    Reset = 1;
    chk("reset CmdReady", CmdReady, 1);
    chk("reset RspValid", RspValid, 0);
    chk("reset RspResult", RspResult, 0);
    chk("reset RspFlags", RspFlags, 0);
    chk("reset RspErr", RspErr, 0);

    run_cmd("add ovf", 4'd2, 24'h7FFFFF, 24'h000001, 24'h800000, 4'b1010, 1'b0, 2);
    run_cmd("sub zero", 4'd3, 24'h000005, 24'h000005, 24'h000000, 4'b0101, 1'b0, 2);
    run_cmd("slt neg", 4'd4, 24'hFFFFFF, 24'h000001, 24'h000001, 4'b0001, 1'b0, 2);
    run_cmd("nor", 4'd5, 24'h0F0F0F, 24'h00FF00, 24'hF000F0, 4'b1000, 1'b0, 2);
    run_cmd("mul small", 4'd6, 24'h000123, 24'h000010, 24'h001230, 4'b0000, 1'b0, 26);
    run_cmd("mul wrap", 4'd6, 24'h001000, 24'h001000, 24'h000000, 4'b0100, 1'b0, 26);
    run_cmd("illegal", 4'hF, 24'h123456, 24'h654321, 24'h000000, 4'b0000, 1'b1, 1);

    // Backpressure: response held 5 cycles, a competing command is ignored
    step();
    CmdValid = 1; CmdOp = 4'd2; CmdA = 24'h000100; CmdB = 24'h000023; RspReady = 0;
    @(negedge Clock);
    #1;
    CmdValid = 0;
    for (int k = 0; k < 10 && !RspValid; k++) step();
    chk("bp valid", RspValid, 1);
    chk("bp result", RspResult, 24'h000123);
    CmdValid = 1; CmdOp = 4'd0; CmdA = 24'hF0F0F0; CmdB = 24'h0FF0FF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp hold valid", RspValid, 1);
      chk("bp hold result", RspResult, 24'h000123);
      chk("bp hold flags", RspFlags, 4'b0000);
      chk("bp hold err", RspErr, 0);
      chk("bp hold ready", CmdReady, 0);
    end
    RspReady = 1;
    step();
    chk("bp release ready", CmdReady, 1);
    chk("bp release valid", RspValid, 0);
    step();
    chk("bp next accepted", CmdReady, 0);
    CmdValid = 0;
    for (int k = 0; k < 10 && !RspValid; k++) step();
    chk("bp next result", RspResult, 24'h00F0F0);
    step();

    // Reset during MUL iteration 10 aborts without a response
    step();
    CmdValid = 1; CmdOp = 4'd6; CmdA = 24'h000123; CmdB = 24'h000010; RspReady = 1;
    @(negedge Clock);
    t = edge_n;
    #1;
    CmdValid = 0;
    for (int k = 0; k < 30 && (edge_n + 1 - t) < 11; k++) step();
    chk("abort iter10 AluA", AluA, 24'h001230);
    chk("abort iter10 AluB", AluB, 24'h048C00);
    Reset = 0;
    step();
    Reset = 1;
    chk("abort CmdReady", CmdReady, 1);
    chk("abort RspResult", RspResult, 0);
    for (int k = 0; k < 30; k++) begin
      step();
      chk("abort no rsp", RspValid, 0);
    end

    // Randomized traffic checked by the compare process
    for (int k = 0; k < 3000; k++) begin
      step();
      Reset    = ($urandom % 400) != 0;
      CmdValid = ($urandom % 3) == 0;
      CmdOp    = (($urandom % 10) < 8) ? 4'($urandom % 7) : 4'($urandom_range(7, 15));
      CmdA     = pick();
      CmdB     = pick();
      RspReady = ($urandom % 3) != 0;
    end
    Reset = 1; CmdValid = 0; RspReady = 1;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Clock  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-low reset.
REQ-003 CmdValid  input  1  command present; CmdReady  output  1  sequencer can accept.
REQ-004 CmdOp  input  4  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 MUL, 7-15 illegal.
REQ-005 CmdA, CmdB  input  24 each  operands (two's complement).
REQ-006 AluA, AluB  output  24 each; AluAInvert, AluBNegate  output  1 each; AluOp  output  3: drive the external 24-bit ALU.
REQ-007 AluResult  input  24; AluZero, AluOverflow, AluCarryOut  input  1 each: combinational return from the ALU.
REQ-008 RspValid  output  1; RspReady  input  1; RspResult  output  24; RspFlags  output  4 {Negative, Zero, Overflow, CarryOut}; RspErr  output  1.

Function
REQ-009 ALU controls per op {AluAInvert, AluBNegate, AluOp}: AND {0,0,000}, OR {0,0,001}, ADD {0,0,010}, SUB {0,1,010}, SLT {0,1,011}, NOR {1,1,000}; MUL uses the ADD controls.
REQ-010 States: IDLE, EXEC, MUL_LOOP, RESP; CmdReady is 1 only in IDLE.
REQ-011 A command is accepted on a cycle with CmdValid and CmdReady both 1; CmdOp, CmdA and CmdB are registered on that edge.
REQ-012 IDLE, accept of ops 0-5 -> EXEC; accept of op 6 -> MUL_LOOP with counter 0; accept of ops 7-15 -> RESP with RspResult 0, RspFlags 0, RspErr 1, and no ALU drive.
REQ-013 EXEC lasts exactly one cycle: the ALU is driven with the registered operands and controls; AluResult is captured into RspResult, {AluResult[23], AluZero, AluOverflow, AluCarryOut} into RspFlags, RspErr 0; next state RESP.
REQ-014 Single-cycle ops: acceptance at edge t means RspValid is 1 from cycle t+2.
REQ-015 MUL_LOOP runs exactly 24 iterations, one per cycle; the accumulator starts at 0, the multiplicand is CmdA and the multiplier is CmdB.
REQ-016 Each MUL iteration drives AluA=accumulator and AluB=multiplicand; when multiplier[0] is 1 the accumulator takes AluResult, otherwise it holds.
REQ-017 Each MUL iteration then shifts the multiplicand left 1 (zero fill, bit 23 dropped) and shifts the multiplier right 1 (logical); the shifts are local and do not pass through the ALU.
REQ-018 MUL result is the low 24 bits of CmdA*CmdB; RspFlags = {result[23], result==0, 0, 0}; RspErr 0; RspValid is 1 from cycle t+26.
REQ-019 Outside EXEC and MUL_LOOP, AluA and AluB are 0, AluOp is 000, and both invert controls are 0.
REQ-020 In RESP, RspValid is 1 and RspResult, RspFlags and RspErr hold stable until a cycle with RspReady 1; that cycle moves to IDLE.
REQ-021 RspValid is 0 in every state other than RESP; CmdValid is ignored while CmdReady is 0.
REQ-022 Maximum throughput is one single-cycle op per 3 cycles when RspReady is held at 1.

Reset
REQ-023 While Reset is 0 at an edge: state goes to IDLE, and CmdReady=1, RspValid=0, RspResult=0, RspFlags=0, RspErr=0, with the ALU outputs per REQ-019.
REQ-024 Reset in any state, including mid-MUL_LOOP or RESP, aborts the command with no response issued.

Structure
REQ-025 Shared package alu_pkg holds the ALUOp encodings, the CmdOp codes, the state enum, the data width constant (24) and the MUL iteration count (24).
REQ-026 No sub-module; the external ALU is instantiated beside this block at the next level up.

Verification
REQ-027 ADD A=0x7FFFFF B=0x000001 -> RspResult 0x800000, Negative 1, Overflow 1, Zero 0, RspValid at t+2.
REQ-028 SUB A=0x000005 B=0x000005 -> RspResult 0x000000, Zero 1, CarryOut 1; SLT A=0xFFFFFF B=0x000001 -> RspResult 0x000001.
REQ-029 MUL A=0x000123 B=0x000010 -> RspResult 0x001230 at t+26; MUL A=0x001000 B=0x001000 -> RspResult 0x000000, Zero 1.
REQ-030 RspReady held 0 for 5 cycles after RspValid -> outputs stable, CmdReady 0; RspReady 1 -> IDLE and next command accepted one cycle later.
REQ-031 CmdOp=0xF -> RspErr 1, RspResult 0 at t+1, ALU outputs stay idle; Reset=0 at iteration 10 of a MUL -> IDLE, no RspValid.
